// File: rtl/id_ex_reg_pkg.sv
// pipe_pkg: shared definitions for the RV32I pipeline registers.
//   XLEN, REG_ADDR_W, ALU_CTRL_W : datapath, register-index and aluControl widths
//   ctrl_word                    : decode control bundle carried down the pipe
//   CTRL_BUBBLE                  : all-zero control word (aluControl 0 = ADD)
//   squash()                     : strips the side-effecting controls from a word
package pipe_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_CTRL_W = 3;

  typedef struct packed {
    logic                  regWrite;
    logic                  resultSrc;
    logic                  memWrite;
    logic                  branch;
    logic                  aluSrc;
    logic [ALU_CTRL_W-1:0] aluControl;
    logic [2:0]            funct3;
  } ctrl_word;

  localparam ctrl_word CTRL_BUBBLE = '0;

  // A bubble must never write the register file or memory and never branch;
  // the other control fields are harmless and pass through.
  function automatic ctrl_word squash(input ctrl_word c);
    ctrl_word r;
    r          = c;
    r.regWrite = 1'b0;
    r.memWrite = 1'b0;
    r.branch   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: decode-side (D) and execute-side (E) signals of the ID/EX register.
//   modport master : drives the D side, observes the E side (decode stage / bench)
//   modport slave  : consumes the D side, drives the E side (the pipeline register)
interface id_ex_reg_if;
  import pipe_pkg::*;

  logic                  validD, regWriteD, resultSrcD, memWriteD, branchD, aluSrcD;
  logic [ALU_CTRL_W-1:0] aluControlD;
  logic [2:0]            funct3D;
  logic [XLEN-1:0]       pcD, pcPlus4D, rd1D, rd2D, immExtD;
  logic [REG_ADDR_W-1:0] rs1D, rs2D, rdD;

  logic                  validE, regWriteE, resultSrcE, memWriteE, branchE, aluSrcE;
  logic [ALU_CTRL_W-1:0] aluControlE;
  logic [2:0]            funct3E;
  logic [XLEN-1:0]       pcE, pcPlus4E, rd1E, rd2E, immExtE;
  logic [REG_ADDR_W-1:0] rs1E, rs2E, rdE;

  modport master (
    output validD, regWriteD, resultSrcD, memWriteD, branchD, aluSrcD,
           aluControlD, funct3D, pcD, pcPlus4D, rd1D, rd2D, immExtD, rs1D, rs2D, rdD,
    input  validE, regWriteE, resultSrcE, memWriteE, branchE, aluSrcE,
           aluControlE, funct3E, pcE, pcPlus4E, rd1E, rd2E, immExtE, rs1E, rs2E, rdE
  );

  modport slave (
    input  validD, regWriteD, resultSrcD, memWriteD, branchD, aluSrcD,
           aluControlD, funct3D, pcD, pcPlus4D, rd1D, rd2D, immExtD, rs1D, rs2D, rdD,
    output validE, regWriteE, resultSrcE, memWriteE, branchE, aluSrcE,
           aluControlE, funct3E, pcE, pcPlus4E, rd1E, rd2E, immExtE, rs1E, rs2E, rdE
  );

endinterface

// File: rtl/id_ex_reg_pipe_reg_en_clr.sv
// pipe_reg_en_clr: generic WIDTH-bit pipeline register, reused by ID/EX, EX/MEM, MEM/WB.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (q <= 0)
//   clr : synchronous clear (q <= 0), below rst
//   en  : load d, below clr; otherwise q holds
//   d/q : data in / registered data out
module pipe_reg_en_clr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register of the RV32I 5-stage core.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, all outputs 0
//   stallE : hold every E output
//   flushE : load a bubble (all zeros); beats stallE
//   bus    : id_ex_reg_if.slave, D-side inputs and registered E-side outputs
//   bubbleCntE : 32-bit count of bubbles loaded, only when ID_EX_BUBBLE_CNT_EN is defined
// A load with validD=0 keeps the data fields but clears regWrite/memWrite/branch/valid.
module id_ex_reg
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallE,
  input  logic        flushE,
  id_ex_reg_if.slave  bus
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubbleCntE
`endif
);

  localparam int unsigned CTRL_W = $bits(ctrl_word) + 1;
  localparam int unsigned DATA_W = 5 * XLEN + 3 * REG_ADDR_W;

  ctrl_word            ctrl_in, ctrl_d, ctrl_e;
  logic                valid_e;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [DATA_W-1:0]   data_q;

  always_comb begin
    ctrl_in = '{regWrite:   bus.regWriteD,
                resultSrc:  bus.resultSrcD,
                memWrite:   bus.memWriteD,
                branch:     bus.branchD,
                aluSrc:     bus.aluSrcD,
                aluControl: bus.aluControlD,
                funct3:     bus.funct3D};
    ctrl_d  = bus.validD ? ctrl_in : squash(ctrl_in);
  end

  pipe_reg_en_clr #(.WIDTH(CTRL_W)) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (!stallE),
    .clr (flushE),
    .d   ({bus.validD, ctrl_d}),
    .q   (ctrl_q)
  );

  pipe_reg_en_clr #(.WIDTH(DATA_W)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (!stallE),
    .clr (flushE),
    .d   ({bus.pcD, bus.pcPlus4D, bus.rd1D, bus.rd2D, bus.immExtD,
           bus.rs1D, bus.rs2D, bus.rdD}),
    .q   (data_q)
  );

  assign {valid_e, ctrl_e} = ctrl_q;

  assign bus.validE      = valid_e;
  assign bus.regWriteE   = ctrl_e.regWrite;
  assign bus.resultSrcE  = ctrl_e.resultSrc;
  assign bus.memWriteE   = ctrl_e.memWrite;
  assign bus.branchE     = ctrl_e.branch;
  assign bus.aluSrcE     = ctrl_e.aluSrc;
  assign bus.aluControlE = ctrl_e.aluControl;
  assign bus.funct3E     = ctrl_e.funct3;

  assign {bus.pcE, bus.pcPlus4E, bus.rd1E, bus.rd2E, bus.immExtE,
          bus.rs1E, bus.rs2E, bus.rdE} = data_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  // A bubble enters on a flush (even during stall) or on an unstalled invalid load.
  logic bubble_load;
  assign bubble_load = flushE || (!stallE && !bus.validD);

  always_ff @(posedge clk) begin
    if (rst)              bubbleCntE <= '0;
    else if (bubble_load) bubbleCntE <= bubbleCntE + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;
  import pipe_pkg::*;

  typedef struct packed {
    logic        valid, regWrite, resultSrc, memWrite, branch, aluSrc;
    logic [2:0]  aluControl;
    logic [2:0]  funct3;
    logic [31:0] pc, pcPlus4, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
  } stage_t;

  logic clk = 1'b0;
  logic rst, stallE, flushE;
  id_ex_reg_if bus();

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  stage_t      model;
  int unsigned model_cnt;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubbleCntE;
  id_ex_reg dut (.clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .bus(bus),
                 .bubbleCntE(bubbleCntE));
`else
  id_ex_reg dut (.clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic drive(input stage_t d);
    bus.validD      = d.valid;
    bus.regWriteD   = d.regWrite;
    bus.resultSrcD  = d.resultSrc;
    bus.memWriteD   = d.memWrite;
    bus.branchD     = d.branch;
    bus.aluSrcD     = d.aluSrc;
    bus.aluControlD = d.aluControl;
    bus.funct3D     = d.funct3;
    bus.pcD         = d.pc;
    bus.pcPlus4D    = d.pcPlus4;
    bus.rd1D        = d.rd1;
    bus.rd2D        = d.rd2;
    bus.immExtD     = d.imm;
    bus.rs1D        = d.rs1;
    bus.rs2D        = d.rs2;
    bus.rdD         = d.rd;
  endtask

  function automatic stage_t observe();
    stage_t o;
    o = '{valid: bus.validE, regWrite: bus.regWriteE, resultSrc: bus.resultSrcE,
          memWrite: bus.memWriteE, branch: bus.branchE, aluSrc: bus.aluSrcE,
          aluControl: bus.aluControlE, funct3: bus.funct3E, pc: bus.pcE,
          pcPlus4: bus.pcPlus4E, rd1: bus.rd1E, rd2: bus.rd2E, imm: bus.immExtE,
          rs1: bus.rs1E, rs2: bus.rs2E, rd: bus.rdE};
    return o;
  endfunction

  function automatic stage_t rand_d();
    stage_t d;
    d = '{valid: 1'($urandom), regWrite: 1'($urandom), resultSrc: 1'($urandom),
          memWrite: 1'($urandom), branch: 1'($urandom), aluSrc: 1'($urandom),
          aluControl: 3'($urandom), funct3: 3'($urandom), pc: $urandom,
          pcPlus4: $urandom, rd1: $urandom, rd2: $urandom, imm: $urandom,
          rs1: 5'($urandom), rs2: 5'($urandom), rd: 5'($urandom)};
    return d;
  endfunction

  task automatic chk_stage(input string tag, input stage_t obs, input stage_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge: apply inputs, advance the reference model, then compare.
  task automatic step(input string tag, input logic r, input logic s, input logic f,
                      input stage_t d);
    rst = r; stallE = s; flushE = f;
    drive(d);
    @(posedge clk);
    if (r) begin
      model = '0; model_cnt = 0;
    end else if (f) begin
      model = '0; model_cnt++;
    end else if (!s) begin
      model = d;
      if (!d.valid) begin
        model.regWrite = 1'b0;
        model.memWrite = 1'b0;
        model.branch   = 1'b0;
        model_cnt++;
      end
    end
    #1;
    chk_stage(tag, observe(), model);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk32({tag, "_cnt"}, bubbleCntE, model_cnt);
`endif
  endtask

  initial begin
    stage_t d, ones;
    ones = '1;
    model = '0;
    model_cnt = 0;
    rst = 1'b1; stallE = 1'b0; flushE = 1'b0;
    drive(ones);

    // Reset with all-ones inputs, then release.
    step("reset0", 1'b1, 1'b0, 1'b0, ones);
    step("reset1", 1'b1, 1'b1, 1'b1, ones);
    chk32("reset_validE", 32'(bus.validE), 32'd0);
    chk32("reset_pcE", bus.pcE, 32'd0);
    step("release", 1'b0, 1'b0, 1'b0, ones);
    chk32("release_pcE", bus.pcE, 32'hFFFF_FFFF);

    // Load latency.
    d = '0;
    d.valid = 1'b1; d.regWrite = 1'b1; d.aluControl = 3'b010;
    d.pc = 32'h10; d.rd1 = 32'h1234_5678; d.rd = 5'd5;
    step("load", 1'b0, 1'b0, 1'b0, d);
    chk32("load_pcE", bus.pcE, 32'h10);
    chk32("load_rd1E", bus.rd1E, 32'h1234_5678);
    chk32("load_rdE", 32'(bus.rdE), 32'd5);
    chk32("load_aluCtl", 32'(bus.aluControlE), 32'd2);

    // x0 destination passes through untouched.
    d.rd = 5'd0;
    step("x0", 1'b0, 1'b0, 1'b0, d);
    chk32("x0_regWriteE", 32'(bus.regWriteE), 32'd1);

    // Stall holds.
    d = rand_d(); d.pc = 32'h20;
    step("stall_load", 1'b0, 1'b0, 1'b0, d);
    d.pc = 32'h24; step("stall1", 1'b0, 1'b1, 1'b0, d);
    d.pc = 32'h28; step("stall2", 1'b0, 1'b1, 1'b0, d);
    d.pc = 32'h2C; step("stall3", 1'b0, 1'b1, 1'b0, d);
    chk32("stall_pcE", bus.pcE, 32'h20);
    step("unstall", 1'b0, 1'b0, 1'b0, d);
    chk32("unstall_pcE", bus.pcE, 32'h2C);

    // Flush beats stall.
    d = rand_d(); d.valid = 1'b1; d.memWrite = 1'b1;
    step("pre_flush", 1'b0, 1'b0, 1'b0, d);
    chk32("pre_flush_mem", 32'(bus.memWriteE), 32'd1);
    step("flush_stall", 1'b0, 1'b1, 1'b1, rand_d());
    chk32("flush_rd1E", bus.rd1E, 32'd0);

    // Invalid load keeps data, drops side effects.
    d = rand_d(); d.valid = 1'b0; d.regWrite = 1'b1; d.memWrite = 1'b1;
    d.branch = 1'b1; d.rd2 = 32'hDEAD_BEEF;
    step("invalid", 1'b0, 1'b0, 1'b0, d);
    chk32("invalid_rd2E", bus.rd2E, 32'hDEAD_BEEF);
    chk32("invalid_ctl", {28'd0, bus.validE, bus.regWriteE, bus.memWriteE, bus.branchE},
          32'd0);

`ifdef ID_EX_BUBBLE_CNT_EN
    d = rand_d(); d.valid = 1'b1;
    step("cnt_rst", 1'b1, 1'b0, 1'b0, d);
    step("cnt_f1", 1'b0, 1'b0, 1'b1, d);
    step("cnt_f2", 1'b0, 1'b0, 1'b1, d);
    d.valid = 1'b0;
    step("cnt_inv", 1'b0, 1'b0, 1'b0, d);
    for (int unsigned i = 0; i < 4; i++) step("cnt_stall", 1'b0, 1'b1, 1'b0, d);
    chk32("cnt_three", bubbleCntE, 32'd3);
    step("cnt_rst2", 1'b1, 1'b0, 1'b0, d);
    chk32("cnt_zero", bubbleCntE, 32'd0);
`endif

    // Randomized traffic against the reference model.
    for (int unsigned i = 0; i < 400; i++) begin
      step("random", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), rand_d());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
